// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Sequencing control in front of a combinational 32-bit ALU. It accepts one
// instruction at a time over a valid/ready handshake, reads two operands from
// an internal register file and drives registered operands, opcode and carry-in
// to the ALU. It then writes the ALU result and flags back and reports
// retirement.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake (ready only while idle)
//   instr[31:0]                {op[5:0], rd, rs1, rs2, use_c, imm[15:0]}
//   alu_a, alu_b, alu_op,      registered ALU inputs; they hold their values
//   alu_cin                    outside decode/execute
//   alu_ans, alu_cout,         ALU result and flags
//   alu_z, alu_n
//   done, done_rd, done_data   one-cycle retirement pulse with its writeback
//   flag_c, flag_z, flag_n     architectural flags
//   illegal                    one-cycle pulse for a rejected class-00 opcode
//   busy                       an instruction is in flight
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_op,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_ans,
    input  logic              alu_cout,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              done,
    output logic [REG_AW-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              illegal,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXECUTE,
        WRITEBACK
    } issueState_t;

    localparam int NumRegs = 2 ** REG_AW;

    issueState_t state;
    issueState_t nextState;

    logic [31:0]       instrReg;
    logic [DATA_W-1:0] regFile [NumRegs];

    logic [5:0]        opField;
    logic [1:0]        opClass;
    logic [REG_AW-1:0] rdIdx;
    logic [REG_AW-1:0] rs1Idx;
    logic [REG_AW-1:0] rs2Idx;
    logic              useC;
    logic [15:0]       immField;
    logic [DATA_W-1:0] immExt;

    logic accept;
    logic loadAlu;
    logic writeAlu;
    logic writeImm;
    logic raiseIllegal;

    // Field extraction from the latched instruction word.
    assign opField  = instrReg[31:26];
    assign opClass  = opField[5:4];
    assign rdIdx    = REG_AW'(instrReg[25:23]);
    assign rs1Idx   = REG_AW'(instrReg[22:20]);
    assign rs2Idx   = REG_AW'(instrReg[19:17]);
    assign useC     = instrReg[16];
    assign immField = instrReg[15:0];
    assign immExt   = {{(DATA_W - 16){immField[15]}}, immField};

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = instr_valid && (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        nextState    = state;
        loadAlu      = 1'b0;
        writeAlu     = 1'b0;
        writeImm     = 1'b0;
        raiseIllegal = 1'b0;
        unique case (state)
            IDLE: begin
                if (instr_valid) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                if (opClass == 2'b00) begin
                    // Class 00 resolves entirely here: NOP, LOADI or reject.
                    nextState = IDLE;
                    if (opField == 6'b000001) begin
                        writeImm = 1'b1;
                    end else if (opField != 6'b000000) begin
                        raiseIllegal = 1'b1;
                    end
                end else begin
                    loadAlu   = 1'b1;
                    nextState = EXECUTE;
                end
            end
            EXECUTE: begin
                // ALU inputs are already registered; this cycle lets them settle.
                nextState = WRITEBACK;
            end
            WRITEBACK: begin
                writeAlu  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Instruction latch, only on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrReg <= '0;
        end else if (accept) begin
            instrReg <= instr;
        end
    end

    // ALU input registers: loaded in decode, held otherwise. The operand read
    // sees the pre-write register value because writeback happens later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            alu_cin <= 1'b0;
        end else if (loadAlu) begin
            alu_a   <= regFile[rs1Idx];
            alu_b   <= regFile[rs2Idx];
            alu_op  <= opField;
            alu_cin <= useC & flag_c;
        end
    end

    // Register file: single write port shared by ALU writeback and LOADI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regFile[i] <= '0;
            end
        end else if (writeAlu) begin
            regFile[rdIdx] <= alu_ans;
        end else if (writeImm) begin
            regFile[rdIdx] <= immExt;
        end
    end

    // Architectural flags: Z/N follow every ALU class, C only arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (writeAlu) begin
            flag_z <= alu_z;
            flag_n <= alu_n;
            if (opClass == 2'b01) begin
                flag_c <= alu_cout;
            end
        end
    end

    // Retirement and rejection reporting, registered so they appear the cycle
    // after the deciding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            done_rd   <= '0;
            done_data <= '0;
            illegal   <= 1'b0;
        end else begin
            done    <= writeAlu | writeImm;
            illegal <= raiseIllegal;
            if (writeAlu) begin
                done_rd   <= rdIdx;
                done_data <= alu_ans;
            end else if (writeImm) begin
                done_rd   <= rdIdx;
                done_data <= immExt;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int K_NOP   = 0;
    localparam int K_LOADI = 1;
    localparam int K_ILL   = 2;
    localparam int K_ALU   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic        alu_cin;
    logic [31:0] alu_ans;
    logic        alu_cout;
    logic        alu_z;
    logic        alu_n;
    logic        done;
    logic [2:0]  done_rd;
    logic [31:0] done_data;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic        illegal;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lastHs = 0;
    int doneCount = 0;

    alu_issue_ctrl #(.DATA_W(32), .REG_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_ans(alu_ans), .alu_cout(alu_cout), .alu_z(alu_z),
        .alu_n(alu_n), .done(done), .done_rd(done_rd), .done_data(done_data),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .illegal(illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Small combinational ALU standing in for the real one.
    function automatic logic [32:0] aluF(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
        logic [32:0] r;
        case (op)
            6'b010000: r = {1'b0, a} + {1'b0, b} + 33'(cin);
            6'b010001: r = {1'b0, a} - {1'b0, b} - 33'(cin);
            6'b100000: r = {32'b0, (a == b)};
            6'b110000: r = {1'b0, a << b[4:0]};
            default:   r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    logic [32:0] aluRes;
    always_comb aluRes = aluF(alu_op, alu_a, alu_b, alu_cin);
    assign alu_ans  = aluRes[31:0];
    assign alu_cout = aluRes[32];
    assign alu_z    = (aluRes[31:0] == 32'd0);
    assign alu_n    = aluRes[31];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic uc, input logic [15:0] imm);
        return {op, rd, rs1, rs2, uc, imm};
    endfunction

    function automatic int kindOf(input logic [5:0] op);
        if (op[5:4] != 2'b00) return K_ALU;
        if (op == 6'd0) return K_NOP;
        if (op == 6'd1) return K_LOADI;
        return K_ILL;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted instruction is a countdown to its retirement event.
    logic [31:0] mR [8];
    logic        mReady, mDone, mIll, mC, mZ, mN, mCin;
    logic [31:0] mA, mB, mData;
    logic [5:0]  mOp;
    logic [2:0]  mRd;
    int          cnt, pKind;
    logic [2:0]  pRd;
    logic [31:0] pVal, pA, pB;
    logic [5:0]  pOp;
    logic        pCin, pCout, pZ, pN, pArith;

    logic [31:0] wA, wB;
    logic        wCin;
    logic [32:0] wRes;
    always_comb begin
        wA   = mR[instr[22:20]];
        wB   = mR[instr[19:17]];
        wCin = instr[16] & mC;
        wRes = aluF(instr[31:26], wA, wB, wCin);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mR[i] <= '0;
            mReady <= 1'b1; mDone <= 1'b0; mIll <= 1'b0;
            mC <= 1'b0; mZ <= 1'b0; mN <= 1'b0;
            mA <= '0; mB <= '0; mOp <= '0; mCin <= 1'b0;
            mData <= '0; mRd <= '0; cnt <= 0; pKind <= K_NOP;
        end else begin
            mDone <= 1'b0;
            mIll  <= 1'b0;
            if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 3) begin
                    mA <= pA; mB <= pB; mOp <= pOp; mCin <= pCin;
                end
                if (cnt == 1) begin
                    mReady <= 1'b1;
                    if (pKind == K_ALU || pKind == K_LOADI) begin
                        mR[pRd] <= pVal; mDone <= 1'b1; mRd <= pRd; mData <= pVal;
                    end
                    if (pKind == K_ALU) begin
                        mZ <= pZ; mN <= pN;
                        if (pArith) mC <= pCout;
                    end
                    if (pKind == K_ILL) mIll <= 1'b1;
                end
            end else if (instr_valid) begin
                mReady <= 1'b0;
                pKind  <= kindOf(instr[31:26]);
                pRd    <= instr[25:23];
                cnt    <= (kindOf(instr[31:26]) == K_ALU) ? 3 : 1;
                pA <= wA; pB <= wB; pOp <= instr[31:26]; pCin <= wCin;
                pCout  <= wRes[32];
                pZ     <= (wRes[31:0] == 32'd0);
                pN     <= wRes[31];
                pArith <= (instr[31:30] == 2'b01);
                pVal   <= (kindOf(instr[31:26]) == K_LOADI) ? {{16{instr[15]}}, instr[15:0]}
                                                             : wRes[31:0];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        chk("instr_ready", 32'(instr_ready), 32'(mReady));
        chk("busy", 32'(busy), 32'(!mReady));
        chk("done", 32'(done), 32'(mDone));
        chk("illegal", 32'(illegal), 32'(mIll));
        chk("flag_c", 32'(flag_c), 32'(mC));
        chk("flag_z", 32'(flag_z), 32'(mZ));
        chk("flag_n", 32'(flag_n), 32'(mN));
        chk("alu_a", alu_a, mA);
        chk("alu_b", alu_b, mB);
        chk("alu_op", 32'(alu_op), 32'(mOp));
        chk("alu_cin", 32'(alu_cin), 32'(mCin));
        if (mDone) begin
            chk("done_rd", 32'(done_rd), 32'(mRd));
            chk("done_data", done_data, mData);
        end
        if (done) doneCount++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] w, input bit hold);
        bit acc;
        bit ok;
        ok = 1'b0;
        instr = w;
        instr_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            acc = instr_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                lastHs = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL handshake_timeout actual=none required=accept");
        end
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic waitDone(input int rd, input logic [31:0] data, input int lat);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #3;
            if (done) begin
                seen = 1'b1;
                chk("lit_done_rd", 32'(done_rd), 32'(rd));
                chk("lit_done_data", done_data, data);
                chk("lit_done_latency", 32'(cyc - lastHs), 32'(lat));
                break;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done required=done");
        end
        @(negedge clk);
    endtask

    task automatic waitIllegal();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #3;
            if (illegal) begin
                seen = 1'b1;
                chk("lit_illegal_latency", 32'(cyc - lastHs), 32'd1);
                break;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL illegal_timeout actual=no_pulse required=pulse");
        end
        @(negedge clk);
    endtask

    task automatic chkFlags(input string nm, input logic c, input logic z, input logic n);
        chk(nm, 32'({flag_c, flag_z, flag_n}), 32'({c, z, n}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int relCyc;
        int hs1, hs2, hs3;
        int dc0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_ready", 32'(instr_ready), 32'd1);
        chk("lit_rst_busy", 32'(busy), 32'd0);
        chk("lit_rst_done_data", done_data, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of EXECUTE drops the ADD into r7.
        send(mk(6'b000001, 3'd1, 3'd0, 3'd0, 1'b0, 16'd5), 1'b0);
        waitDone(1, 32'd5, 1);
        send(mk(6'b000001, 3'd2, 3'd0, 3'd0, 1'b0, 16'd3), 1'b0);
        waitDone(2, 32'd3, 1);
        send(mk(6'b010000, 3'd7, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
        @(negedge clk);
        chk("lit_exec_busy", 32'(busy), 32'd1);
        chk("lit_exec_alu_a", alu_a, 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("lit_rst_alu_a", alu_a, 32'd0);
        chk("lit_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        relCyc = cyc;
        send(mk(6'b010000, 3'd0, 3'd7, 3'd7, 1'b0, 16'd0), 1'b0);
        chk("lit_accept_after_reset", 32'(lastHs - relCyc), 32'd1);
        waitDone(0, 32'd0, 3);

        // ADD 5 + 3.
        send(mk(6'b000001, 3'd1, 3'd0, 3'd0, 1'b0, 16'd5), 1'b0);
        waitDone(1, 32'd5, 1);
        send(mk(6'b000001, 3'd2, 3'd0, 3'd0, 1'b0, 16'd3), 1'b0);
        waitDone(2, 32'd3, 1);
        send(mk(6'b010000, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
        waitDone(3, 32'd8, 3);
        chkFlags("lit_add_flags", 1'b0, 1'b0, 1'b0);

        // SUB 3 - 5 borrows.
        send(mk(6'b000001, 3'd1, 3'd0, 3'd0, 1'b0, 16'd3), 1'b0);
        waitDone(1, 32'd3, 1);
        send(mk(6'b000001, 3'd2, 3'd0, 3'd0, 1'b0, 16'd5), 1'b0);
        waitDone(2, 32'd5, 1);
        send(mk(6'b010001, 3'd4, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
        waitDone(4, 32'hFFFF_FFFE, 3);
        chkFlags("lit_sub_flags", 1'b1, 1'b0, 1'b1);

        // Sign-extended LOADI, carry out, then carry in.
        send(mk(6'b000001, 3'd1, 3'd0, 3'd0, 1'b0, 16'hFFFF), 1'b0);
        waitDone(1, 32'hFFFF_FFFF, 1);
        send(mk(6'b000001, 3'd2, 3'd0, 3'd0, 1'b0, 16'd1), 1'b0);
        waitDone(2, 32'd1, 1);
        send(mk(6'b010000, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0), 1'b0);
        waitDone(5, 32'd0, 3);
        chkFlags("lit_carry_flags", 1'b1, 1'b1, 1'b0);
        send(mk(6'b010000, 3'd6, 3'd0, 3'd0, 1'b1, 16'd0), 1'b0);
        @(posedge clk);
        #3;
        chk("lit_alu_cin", 32'(alu_cin), 32'd1);
        waitDone(6, 32'd1, 3);
        chkFlags("lit_cin_flags", 1'b0, 1'b0, 1'b0);

        // Illegal opcode, then NOP.
        send(mk(6'b000111, 3'd1, 3'd0, 3'd0, 1'b0, 16'h1234), 1'b0);
        waitIllegal();
        chkFlags("lit_illegal_flags", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        send(32'd0, 1'b0);
        repeat (4) @(negedge clk);

        // Back-to-back ALU ops with valid held: ADD sets C, EQ must keep it.
        dc0 = doneCount;
        send(mk(6'b010000, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0), 1'b1);
        hs1 = lastHs;
        send(mk(6'b100000, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0), 1'b1);
        hs2 = lastHs;
        send(mk(6'b110000, 3'd5, 3'd2, 3'd2, 1'b0, 16'd0), 1'b0);
        hs3 = lastHs;
        waitDone(5, 32'd2, 3);
        chk("lit_hs_gap1", 32'(hs2 - hs1), 32'd4);
        chk("lit_hs_gap2", 32'(hs3 - hs2), 32'd4);
        chk("lit_b2b_done_count", 32'(doneCount - dc0), 32'd3);
        chkFlags("lit_eq_keeps_c", 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
